collision_detector: RTL and testbench

Per-frame sprite collision detector for the game datapath. Once per frame it serially compares the player's bounding box against up to N_OBJ enemy boxes. When a new overlap is found it emits a one-cycle `collision` pulse. That pulse drives the downstream `holder` stage's `signal_in`, which stretches it for the game-logic and display consumers.

---
 rtl/game_pkg.sv | 14 +
 rtl/collision_detector_if.sv | 31 +++
 rtl/collision_detector_box_overlap.sv | 32 +++
 rtl/collision_detector.sv | 128 ++++++++++++
 tb/tb_collision_detector.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: FSM encodings and default sprite geometry.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int COORD_W_DEF = 11;
    localparam int SPRITE_DIM  = 32;
    localparam int N_OBJ_DEF   = 4;

endpackage

// File: rtl/collision_detector_if.sv
// Frame-scan request/result bundle between game logic (master) and collision_detector (slave).
interface collision_detector_if
    import game_pkg::*;
#(
    parameter int N_OBJ   = N_OBJ_DEF,
    parameter int COORD_W = COORD_W_DEF
);
    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    logic                       frame_start;
    logic [COORD_W-1:0]         player_x;
    logic [COORD_W-1:0]         player_y;
    logic [N_OBJ*COORD_W-1:0]   obj_x_bus;
    logic [N_OBJ*COORD_W-1:0]   obj_y_bus;
    logic [N_OBJ-1:0]           obj_valid;
    logic                       collision;
    logic [IDX_W-1:0]           collision_idx;
    logic [N_OBJ-1:0]           collision_mask;
    logic                       busy;

    modport master (
        output frame_start, player_x, player_y, obj_x_bus, obj_y_bus, obj_valid,
        input  collision, collision_idx, collision_mask, busy
    );

    modport slave (
        input  frame_start, player_x, player_y, obj_x_bus, obj_y_bus, obj_valid,
        output collision, collision_idx, collision_mask, busy
    );

endinterface

// File: rtl/collision_detector_box_overlap.sv
// Strict axis-aligned box overlap test; right/bottom edges are formed one bit wider so they never wrap.
module box_overlap #(
    parameter int COORD_W  = 11,
    parameter int PLAYER_W = 32,
    parameter int PLAYER_H = 32,
    parameter int OBJ_W    = 32,
    parameter int OBJ_H    = 32
) (
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] ox,
    input  logic [COORD_W-1:0] oy,
    output logic               hit
);
    localparam int SUM_W = COORD_W + 1;

    logic [SUM_W-1:0] px_l, py_t, ox_l, oy_t;
    logic [SUM_W-1:0] px_r, py_b, ox_r, oy_b;

    assign px_l = {1'b0, px};
    assign py_t = {1'b0, py};
    assign ox_l = {1'b0, ox};
    assign oy_t = {1'b0, oy};

    assign px_r = px_l + SUM_W'(PLAYER_W);
    assign py_b = py_t + SUM_W'(PLAYER_H);
    assign ox_r = ox_l + SUM_W'(OBJ_W);
    assign oy_b = oy_t + SUM_W'(OBJ_H);

    assign hit = (px_l < ox_r) && (ox_l < px_r) && (py_t < oy_b) && (oy_t < py_b);

endmodule

// File: rtl/collision_detector.sv
// Per-frame serial scan of the player box against N_OBJ object slots, reporting newly started overlaps.
//   state  | meaning
//   IDLE   | waiting for frame_start; inputs snapshotted on acceptance
//   SCAN   | one snapshot slot evaluated per cycle, index 0..N_OBJ-1
//   REPORT | publish mask, raise collision for hits absent last frame
module collision_detector
    import game_pkg::*;
#(
    parameter int N_OBJ    = N_OBJ_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int PLAYER_W = SPRITE_DIM,
    parameter int PLAYER_H = SPRITE_DIM,
    parameter int OBJ_W    = SPRITE_DIM,
    parameter int OBJ_H    = SPRITE_DIM
) (
    input  logic               clk,
    input  logic               rst,
    collision_detector_if.slave bus
);
    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    state_t             state;
    logic [COORD_W-1:0] px_q, py_q;
    logic [COORD_W-1:0] ox_q [N_OBJ];
    logic [COORD_W-1:0] oy_q [N_OBJ];
    logic [N_OBJ-1:0]   valid_q;
    logic [IDX_W-1:0]   cnt;
    logic [N_OBJ-1:0]   hit_q;
    logic [N_OBJ-1:0]   prev_mask;
    logic               slot_hit;

    logic               coll_q;
    logic [IDX_W-1:0]   idx_q;
    logic [N_OBJ-1:0]   mask_q;
    logic               busy_q;

    logic [N_OBJ-1:0]   new_hits;
    logic [IDX_W-1:0]   new_idx;

    box_overlap #(
        .COORD_W  (COORD_W),
        .PLAYER_W (PLAYER_W),
        .PLAYER_H (PLAYER_H),
        .OBJ_W    (OBJ_W),
        .OBJ_H    (OBJ_H)
    ) u_overlap (
        .px  (px_q),
        .py  (py_q),
        .ox  (ox_q[cnt]),
        .oy  (oy_q[cnt]),
        .hit (slot_hit)
    );

    // Lowest set bit wins: scan from the top so the smallest index is written last.
    always_comb begin
        new_hits = hit_q & ~prev_mask;
        new_idx  = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (new_hits[i]) new_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            px_q      <= '0;
            py_q      <= '0;
            valid_q   <= '0;
            cnt       <= '0;
            hit_q     <= '0;
            prev_mask <= '0;
            coll_q    <= 1'b0;
            idx_q     <= '0;
            mask_q    <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < N_OBJ; i++) begin
                ox_q[i] <= '0;
                oy_q[i] <= '0;
            end
        end else begin
            coll_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        px_q    <= bus.player_x;
                        py_q    <= bus.player_y;
                        valid_q <= bus.obj_valid;
                        for (int i = 0; i < N_OBJ; i++) begin
                            ox_q[i] <= bus.obj_x_bus[i*COORD_W +: COORD_W];
                            oy_q[i] <= bus.obj_y_bus[i*COORD_W +: COORD_W];
                        end
                        cnt    <= '0;
                        hit_q  <= '0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    hit_q[cnt] <= valid_q[cnt] & slot_hit;
                    if (cnt == IDX_W'(N_OBJ - 1)) begin
                        state <= REPORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REPORT: begin
                    coll_q <= |new_hits;
                    if (|new_hits) idx_q <= new_idx;
                    mask_q    <= hit_q;
                    prev_mask <= hit_q;
                    cnt       <= '0;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.collision      = coll_q;
    assign bus.collision_idx  = idx_q;
    assign bus.collision_mask = mask_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench: frame-level reference model compared every cycle, directed scenarios plus random traffic.
module tb_collision_detector;
    import game_pkg::*;

    localparam int N    = 4;
    localparam int CW   = 11;
    localparam int DIM  = 32;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    collision_detector_if #(.N_OBJ(N), .COORD_W(CW)) bus_if ();

    collision_detector #(
        .N_OBJ    (N),
        .COORD_W  (CW),
        .PLAYER_W (DIM),
        .PLAYER_H (DIM),
        .OBJ_W    (DIM),
        .OBJ_H    (DIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int busy_cnt = 0;
    int last_pulse_cyc = 0;

    int px, py;
    int ox [N];
    int oy [N];
    logic [N-1:0] vld;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply();
        bus_if.player_x = CW'(px);
        bus_if.player_y = CW'(py);
        for (int i = 0; i < N; i++) begin
            bus_if.obj_x_bus[i*CW +: CW] = CW'(ox[i]);
            bus_if.obj_y_bus[i*CW +: CW] = CW'(oy[i]);
        end
        bus_if.obj_valid = vld;
    endtask

    task automatic set_far();
        for (int i = 0; i < N; i++) begin
            ox[i] = 600;
            oy[i] = 600;
        end
        vld = '0;
    endtask

    // Reference: a frame is an (N+1)-cycle window; hits come from plain integer box arithmetic.
    int           scan_left = 0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_prev = '0;
    logic [N-1:0] m_mask = '0;
    logic [1:0]   m_idx  = '0;
    logic         m_coll = 1'b0;

    function automatic logic [N-1:0] calc_hits();
        logic [N-1:0] h;
        int qx, qy, bx, by;
        h  = '0;
        qx = int'(bus_if.player_x);
        qy = int'(bus_if.player_y);
        for (int i = 0; i < N; i++) begin
            bx = int'(bus_if.obj_x_bus[i*CW +: CW]);
            by = int'(bus_if.obj_y_bus[i*CW +: CW]);
            h[i] = bus_if.obj_valid[i] && (qx < bx + DIM) && (bx < qx + DIM)
                   && (qy < by + DIM) && (by < qy + DIM);
        end
        return h;
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [N-1:0] nw;
        logic found;
        if (!rst) begin
            scan_left = 0;
            m_pend = '0;
            m_prev = '0;
            m_mask = '0;
            m_idx  = '0;
            m_coll = 1'b0;
        end else begin
            m_coll = 1'b0;
            if (scan_left == 0) begin
                if (bus_if.frame_start) begin
                    m_pend    = calc_hits();
                    scan_left = N + 1;
                end
            end else begin
                scan_left--;
                if (scan_left == 0) begin
                    nw     = m_pend & ~m_prev;
                    m_coll = (nw != '0);
                    found  = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        if (nw[i] && !found) begin
                            m_idx = 2'(i);
                            found = 1'b1;
                        end
                    end
                    m_mask = m_pend;
                    m_prev = m_pend;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        cyc++;
        #1;
        chk("busy", 32'(bus_if.busy), 32'(scan_left > 0));
        chk("collision", 32'(bus_if.collision), 32'(m_coll));
        chk("idx", 32'(bus_if.collision_idx), 32'(m_idx));
        chk("mask", 32'(bus_if.collision_mask), 32'(m_mask));
        if (bus_if.collision === 1'b1) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
        end
        if (bus_if.busy === 1'b1) busy_cnt++;
    end

    int f_pulses, f_busy, f_lat;

    task automatic run_frame(input int dup_at, input int rst_at);
        int p0, b0, t0;
        p0 = pulse_cnt;
        b0 = busy_cnt;
        @(negedge clk);
        bus_if.frame_start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        bus_if.frame_start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus_if.frame_start = (i == dup_at);
            rst = !(i == rst_at);
        end
        bus_if.frame_start = 1'b0;
        rst = 1'b1;
        f_pulses = pulse_cnt - p0;
        f_busy   = busy_cnt - b0;
        f_lat    = last_pulse_cyc - t0;
    endtask

    function automatic int clampc(input int v);
        if (v < 0) return 0;
        if (v > CMAX) return CMAX;
        return v;
    endfunction

    task automatic randomize_cfg();
        px = $urandom_range(0, CMAX);
        py = $urandom_range(0, CMAX);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                ox[i] = clampc(px + $urandom_range(0, 80) - 40);
                oy[i] = clampc(py + $urandom_range(0, 80) - 40);
            end else begin
                ox[i] = $urandom_range(0, CMAX);
                oy[i] = $urandom_range(0, CMAX);
            end
        end
        vld = N'($urandom_range(0, (1 << N) - 1));
        apply();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.frame_start = 1'b0;
        px = 100;
        py = 100;
        set_far();
        apply();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus_if.busy), 32'd0);
        chk("reset_mask", 32'(bus_if.collision_mask), 32'd0);
        chk("reset_no_pulse", 32'(pulse_cnt), 32'd0);

        // basic hit in slot 2
        px = 100; py = 100;
        set_far();
        ox[2] = 120; oy[2] = 110; vld = 4'b0100;
        apply();
        run_frame(0, 0);
        chk("s2_pulses", 32'(f_pulses), 32'd1);
        chk("s2_latency", 32'(f_lat), 32'd5);
        chk("s2_busy_len", 32'(f_busy), 32'd5);
        chk("s2_idx", 32'(bus_if.collision_idx), 32'd2);
        chk("s2_mask", 32'(bus_if.collision_mask), 32'b0100);
        chk("s2_model_mask", 32'(m_mask), 32'b0100);

        // same overlap persists: no new pulse
        run_frame(0, 0);
        chk("s4a_pulses", 32'(f_pulses), 32'd0);
        chk("s4a_mask", 32'(bus_if.collision_mask), 32'b0100);
        chk("s4a_idx_hold", 32'(bus_if.collision_idx), 32'd2);

        ox[1] = 90; oy[1] = 90; vld = 4'b0110;
        apply();
        run_frame(0, 0);
        chk("s4b_pulses", 32'(f_pulses), 32'd1);
        chk("s4b_idx", 32'(bus_if.collision_idx), 32'd1);
        chk("s4b_mask", 32'(bus_if.collision_mask), 32'b0110);

        // edge touch and invalid slot
        set_far();
        ox[0] = 132; oy[0] = 100; vld[0] = 1'b1;
        ox[1] = 100; oy[1] = 100;
        apply();
        run_frame(0, 0);
        chk("s3_pulses", 32'(f_pulses), 32'd0);
        chk("s3_mask", 32'(bus_if.collision_mask), 32'd0);
        chk("s3_idx_hold", 32'(bus_if.collision_idx), 32'd1);

        // wrap-around must not produce a hit
        px = 2030; py = 100;
        set_far();
        ox[3] = 10; oy[3] = 100; vld = 4'b1000;
        apply();
        run_frame(0, 0);
        chk("s5_pulses", 32'(f_pulses), 32'd0);
        chk("s5_mask", 32'(bus_if.collision_mask), 32'd0);
        chk("s5_model_mask", 32'(m_mask), 32'd0);

        // duplicate start mid-scan is ignored
        px = 100; py = 100;
        set_far();
        ox[2] = 120; oy[2] = 110; vld = 4'b0100;
        apply();
        run_frame(1, 0);
        chk("s6a_pulses", 32'(f_pulses), 32'd1);
        chk("s6a_busy_len", 32'(f_busy), 32'd5);
        chk("s6a_mask", 32'(bus_if.collision_mask), 32'b0100);

        // reset mid-scan discards the frame and clears state
        run_frame(0, 1);
        chk("s6b_pulses", 32'(f_pulses), 32'd0);
        chk("s6b_mask", 32'(bus_if.collision_mask), 32'd0);
        chk("s6b_idx", 32'(bus_if.collision_idx), 32'd0);
        chk("s6b_busy", 32'(bus_if.busy), 32'd0);

        run_frame(0, 0);
        chk("s6c_pulses", 32'(f_pulses), 32'd1);
        chk("s6c_latency", 32'(f_lat), 32'd5);
        chk("s6c_idx", 32'(bus_if.collision_idx), 32'd2);
        chk("s6c_mask", 32'(bus_if.collision_mask), 32'b0100);

        // random traffic: starts at any time, inputs changing mid-scan, occasional resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = 1'b1;
            bus_if.frame_start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) randomize_cfg();
            if ($urandom_range(0, 199) == 0) rst = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        bus_if.frame_start = 1'b0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
